// File: rtl/cpu_sequencer_if.sv
// Board-side control and datapath-side instruction bundle
// for the demo CPU sequencer.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              run;
  logic              step;
  logic              clear;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [7:0]        instr;
  logic              exec;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;

  modport master (
    output run, step, clear,
    output load_we, load_addr, load_data,
    input  instr, exec, pc, busy, halted
  );

  modport slave (
    input  run, step, clear,
    input  load_we, load_addr, load_data,
    output instr, exec, pc, busy, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer with a small loadable
// program memory, in-sequencer jump and halt handling.
module cpu_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_e;

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        mem_q [DEPTH];

  logic              is_halt;
  logic              is_jmp;
  logic              we_ok;
  logic [ADDR_W-1:0] pc_inc;

  assign is_halt = (ir_q[3:0] == 4'hF);
  assign is_jmp  = (ir_q[3:0] == 4'hE);
  assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  assign we_ok = bus.load_we &&
                 (state_q == IDLE ||
                  state_q == HALT);

  // Program memory write; not reset, only loaded when quiet.
  always_ff @(posedge clk) begin
    if (we_ok) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // State, program counter and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.run || bus.step) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        state_d = EXEC;
      end
      EXEC: begin
        unique case (1'b1)
          is_halt: begin
            state_d = HALT;
          end
          is_jmp: begin
            pc_d    = ir_q[ADDR_W+3:4];
            state_d = bus.run ? FETCH : IDLE;
          end
          default: begin
            pc_d    = pc_inc;
            state_d = bus.run ? FETCH : IDLE;
          end
        endcase
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      pc_d    = '0;
    end
  end

  assign bus.instr  = ir_q;
  assign bus.pc     = pc_q;
  assign bus.exec   = (state_q == EXEC) &&
                      !is_halt && !is_jmp;
  assign bus.busy   = (state_q == FETCH) ||
                      (state_q == DECODE) ||
                      (state_q == EXEC);
  assign bus.halted = (state_q == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer against a
// program-level reference model.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_sequencer_if #(.ADDR_W(4)) bus ();

  cpu_sequencer #(.ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] instr;
    logic [3:0] pc;
  } exp_t;

  exp_t       sbq [$];
  logic [7:0] mem_m [16];
  logic [3:0] mpc;
  logic [7:0] m_ir;
  logic       mhalt;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: run one instruction at program level.
  task automatic m_exec(input int slot);
    logic [7:0] w;
    w    = mem_m[mpc];
    m_ir = w;
    if (w[3:0] == 4'hF) begin
      mhalt = 1'b1;
    end else if (w[3:0] == 4'hE) begin
      mpc = w[7:4];
    end else begin
      mpc = mpc + 4'd1;
      sbq.push_back('{cyc: slot, instr: w, pc: mpc});
    end
  endtask

  function automatic logic [7:0] rand_word();
    int         c;
    logic [3:0] hi;
    c  = $urandom_range(0, 11);
    hi = 4'($urandom);
    if (c == 0) return {hi, 4'hF};
    if (c <= 2) return {hi, 4'hE};
    return {hi, 4'($urandom_range(0, 13))};
  endfunction

  task automatic settle(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_pc"}, bus.pc, mpc);
    chk({nm, "_halted"}, bus.halted, mhalt);
    chk({nm, "_instr"}, bus.instr, m_ir);
  endtask

  task automatic load(input logic [3:0] a,
                      input logic [7:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    mem_m[a]      = d;
    tick();
    bus.load_we   = 1'b0;
  endtask

  task automatic do_step(input string nm);
    int s;
    s = cyc;
    bus.step = 1'b1;
    if (!mhalt) m_exec(s + 3);
    tick();
    bus.step = 1'b0;
    repeat (4) tick();
    settle(nm);
  endtask

  task automatic do_run(input string nm, input int n);
    int s;
    int r;
    int k;
    s = cyc;
    r = s + n;
    k = 0;
    while (!mhalt && (k == 0 || s + 3 * k < r)) begin
      m_exec(s + 3 + 3 * k);
      k++;
    end
    bus.run = 1'b1;
    repeat (n) tick();
    bus.run = 1'b0;
    repeat (4) tick();
    settle(nm);
  endtask

  task automatic do_clear(input string nm);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    mpc   = 4'd0;
    mhalt = 1'b0;
    tick();
    settle(nm);
  endtask

  // Monitor: every exec pulse must match the next prediction.
  logic       pend = 1'b0;
  logic [3:0] pend_pc;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (pend) begin
        chk("pc_after_exec", bus.pc, pend_pc);
        pend = 1'b0;
      end
      if (bus.exec === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_exec", cyc, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("exec_cycle", cyc, e.cyc);
          chk("exec_instr", bus.instr, e.instr);
          pend    = 1'b1;
          pend_pc = e.pc;
        end
      end
    end
  end

  initial begin
    int s;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.clear     = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    rst_n         = 1'b0;
    mpc   = 4'd0;
    m_ir  = 8'h00;
    mhalt = 1'b0;
    tick();
    chk("rst_exec", bus.exec, 0);
    settle("rst");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    settle("idle_hold");

    for (int i = 0; i < 16; i++) load(4'(i), 8'h01);
    load(4'd0, 8'h51);
    load(4'd1, 8'h62);
    do_step("step1");
    do_step("step2");

    s = cyc;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
    tick();
    chk("exec_before_rst", bus.exec, 1);
    rst_n = 1'b0;
    #1;
    mpc  = 4'd0;
    m_ir = 8'h00;
    chk("rst_async_exec", bus.exec, 0);
    settle("rst_async");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    settle("post_rst_idle");

    load(4'd0, 8'h01);
    load(4'd1, 8'h01);
    do_run("wrap", 48);

    load(4'd0, 8'h31);
    load(4'd1, 8'h5E);
    load(4'd5, 8'h0F);
    do_run("jmp_halt", 30);
    do_step("halt_step");
    do_run("halt_run", 6);
    do_clear("clear");

    s = cyc;
    bus.step = 1'b1;
    m_exec(s + 3);
    tick();
    bus.step      = 1'b0;
    bus.load_we   = 1'b1;
    bus.load_addr = mpc;
    bus.load_data = 8'hAB;
    tick();
    bus.load_we   = 1'b0;
    repeat (3) tick();
    settle("fetch_load");
    do_step("fetch_load_chk");

    s = cyc;
    bus.load_we   = 1'b1;
    bus.load_addr = mpc;
    bus.load_data = 8'h47;
    bus.step      = 1'b1;
    mem_m[mpc]    = 8'h47;
    m_exec(s + 3);
    tick();
    bus.load_we = 1'b0;
    bus.step    = 1'b0;
    tick();
    chk("collide_decode_instr", bus.instr, 8'h47);
    repeat (3) tick();
    settle("collide");

    s = cyc;
    bus.step = 1'b1;
    m_exec(s + 3);
    repeat (4) tick();
    bus.step = 1'b0;
    tick();
    settle("busy_step");

    for (int rnd = 0; rnd < 30; rnd++) begin
      repeat ($urandom_range(1, 6))
        load(4'($urandom), rand_word());
      if (mhalt && $urandom_range(0, 1) == 1)
        do_clear("rnd_clear");
      case ($urandom_range(0, 5))
        0, 1:    do_step("rnd_step");
        5:       do_clear("rnd_clr");
        default: do_run("rnd_run", $urandom_range(1, 40));
      endcase
    end

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
